mdu_stall_ctrl: RTL and testbench

//   Sequences the multi-cycle mult/div unit (MDU) in the 5-stage pipeline.

---
 rtl/mdu_pkg.sv | 32 +++
 rtl/mdu_stall_ctrl_if.sv | 27 ++
 rtl/mdu_busy_counter.sv | 33 +++
 rtl/mdu_stall_ctrl.sv | 87 ++++++++
 tb/tb_mdu_stall_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op encodings, sequencer states, default latencies.
package mdu_pkg;

  localparam logic [1:0] MD_OP_MULT  = 2'b00;
  localparam logic [1:0] MD_OP_MULTU = 2'b01;
  localparam logic [1:0] MD_OP_DIV   = 2'b10;
  localparam logic [1:0] MD_OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  // Busy length for an op; signed/unsigned variants share latency.
  function automatic int unsigned md_op_cycles(input logic [1:0]  op,
                                               input int unsigned mult_cycles,
                                               input int unsigned div_cycles);
    int unsigned n;
    n = mult_cycles;
    unique case (op)
      MD_OP_MULT, MD_OP_MULTU: n = mult_cycles;
      MD_OP_DIV, MD_OP_DIVU:   n = div_cycles;
      default:                 n = mult_cycles;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mdu_stall_ctrl_if.sv
// Pipeline <-> MDU sequencer signal bundle. The slave side is the sequencer.
interface mdu_stall_ctrl_if #(
  parameter int unsigned CNT_W = 4
);
  logic             E_MDstart_i;
  logic [1:0]       E_MDop_i;
  logic             D_MDuse_i;
  logic             D_hzd_stall_i;
  logic             MD_busy_o;
  logic             MD_done_o;
  logic [CNT_W-1:0] MD_cnt_o;
  logic             stall_o;
  logic             F_en_o;
  logic             D_en_o;
  logic             E_flush_o;
  logic             MD_err_o;

  modport slave (
    input  E_MDstart_i, E_MDop_i, D_MDuse_i, D_hzd_stall_i,
    output MD_busy_o, MD_done_o, MD_cnt_o, stall_o, F_en_o, D_en_o, E_flush_o, MD_err_o
  );

  modport master (
    output E_MDstart_i, E_MDop_i, D_MDuse_i, D_hzd_stall_i,
    input  MD_busy_o, MD_done_o, MD_cnt_o, stall_o, F_en_o, D_en_o, E_flush_o, MD_err_o
  );
endinterface

// File: rtl/mdu_busy_counter.sv
// Remaining-busy-cycle counter: load, decrement, last-cycle detect.
module mdu_busy_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  // Load wins over decrement; saturate at zero so a stray dec never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && !cnt_zero) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mdu_stall_ctrl.sv
// MDU sequencer: tracks busy time of mult/div, pulses HI/LO write on completion,
// and merges the MDU-busy stall with the D-stage hazard stall.
module mdu_stall_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  // Must hold max(MULT_CYCLES, DIV_CYCLES) and match the interface CNT_W.
  parameter int unsigned CNT_W       = 4
) (
  input logic              clk,
  input logic              reset,
  mdu_stall_ctrl_if.slave  bus
);

  md_state_e        state_q;
  logic             done_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;
  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_load_val;
  logic             busy;
  logic             stall;

  // A start is only accepted outside BUSY; a start in BUSY is an error, not a reload.
  assign cnt_load     = bus.E_MDstart_i && (state_q != ST_BUSY);
  assign cnt_dec      = (state_q == ST_BUSY);
  assign cnt_load_val = CNT_W'(md_op_cycles(bus.E_MDop_i, MULT_CYCLES, DIV_CYCLES));

  mdu_busy_counter #(
    .CNT_W (CNT_W)
  ) u_busy_counter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt),
    .last_o     (cnt_last)
  );

  // Sequencer FSM with registered done pulse and sticky overlap error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.E_MDstart_i) state_q <= ST_BUSY;
        end
        ST_BUSY: begin
          if (bus.E_MDstart_i) err_q <= 1'b1;
          if (cnt_last) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          // Back-to-back start is legal: the finished op still gets its write.
          state_q <= bus.E_MDstart_i ? ST_BUSY : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Busy includes the start cycle so a dependent D-stage op stalls immediately;
  // the DONE cycle is not busy (the datapath forwards that cycle's HI/LO write).
  assign busy  = (state_q == ST_BUSY) || bus.E_MDstart_i;
  assign stall = bus.D_hzd_stall_i || (bus.D_MDuse_i && busy);

  assign bus.MD_busy_o = busy;
  assign bus.MD_done_o = done_q;
  assign bus.MD_cnt_o  = cnt;
  assign bus.MD_err_o  = err_q;
  assign bus.stall_o   = stall;
  assign bus.F_en_o    = !stall;
  assign bus.D_en_o    = !stall;
  // Bubble only; the op already in E keeps running in the MDU.
  assign bus.E_flush_o = stall;

endmodule

// File: tb/tb_mdu_stall_ctrl.sv
// Directed bench for mdu_stall_ctrl with hand-computed expectations
// (MULT_CYCLES=5, DIV_CYCLES=10).
module tb_mdu_stall_ctrl;
  import mdu_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  mdu_stall_ctrl_if #(.CNT_W(4)) bus ();

  mdu_stall_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    bus.E_MDstart_i   = 1'b0;
    bus.E_MDop_i      = MD_OP_MULT;
    bus.D_MDuse_i     = 1'b0;
    bus.D_hzd_stall_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy",  bus.MD_busy_o, 0);
    check_eq("rst_done",  bus.MD_done_o, 0);
    check_eq("rst_cnt",   bus.MD_cnt_o,  0);
    check_eq("rst_err",   bus.MD_err_o,  0);
    check_eq("rst_stall", bus.stall_o,   0);
    check_eq("rst_fen",   bus.F_en_o,    1);
    check_eq("rst_flush", bus.E_flush_o, 0);
    reset = 1'b1;
    tick();

    // Mult, no D use: busy t..t+5, done at t+6, never stalls.
    bus.E_MDstart_i = 1'b1;
    bus.E_MDop_i    = MD_OP_MULT;
    #1;
    check_eq("mul_busy_t",  bus.MD_busy_o, 1);
    check_eq("mul_stall_t", bus.stall_o,   0);
    tick();
    bus.E_MDstart_i = 1'b0;
    #1;
    for (int k = 1; k <= 5; k++) begin
      check_eq("mul_busy",  bus.MD_busy_o, 1);
      check_eq("mul_cnt",   bus.MD_cnt_o,  6 - k);
      check_eq("mul_done0", bus.MD_done_o, 0);
      check_eq("mul_stall", bus.stall_o,   0);
      tick();
    end
    check_eq("mul_done",     bus.MD_done_o, 1);
    check_eq("mul_busy_end", bus.MD_busy_o, 0);
    check_eq("mul_cnt_end",  bus.MD_cnt_o,  0);
    tick();
    check_eq("mul_done_off", bus.MD_done_o, 0);

    // Div with mflo in D from t+1: stall t+1..t+10, release at t+11.
    bus.E_MDstart_i = 1'b1;
    bus.E_MDop_i    = MD_OP_DIV;
    #1;
    check_eq("div_stall_t", bus.stall_o, 0);
    tick();
    bus.E_MDstart_i = 1'b0;
    bus.D_MDuse_i   = 1'b1;
    #1;
    for (int k = 1; k <= 10; k++) begin
      check_eq("div_stall", bus.stall_o,   1);
      check_eq("div_flush", bus.E_flush_o, 1);
      check_eq("div_fen",   bus.F_en_o,    0);
      check_eq("div_den",   bus.D_en_o,    0);
      check_eq("div_cnt",   bus.MD_cnt_o,  11 - k);
      tick();
    end
    check_eq("div_rel_stall", bus.stall_o,   0);
    check_eq("div_rel_fen",   bus.F_en_o,    1);
    check_eq("div_rel_flush", bus.E_flush_o, 0);
    check_eq("div_rel_done",  bus.MD_done_o, 1);
    bus.D_MDuse_i = 1'b0;
    tick();

    // Hazard stall while idle, no MDU use.
    bus.D_hzd_stall_i = 1'b1;
    #1;
    check_eq("hzd_stall", bus.stall_o,   1);
    check_eq("hzd_busy",  bus.MD_busy_o, 0);
    check_eq("hzd_cnt",   bus.MD_cnt_o,  0);
    check_eq("hzd_fen",   bus.F_en_o,    0);
    check_eq("hzd_flush", bus.E_flush_o, 1);
    bus.D_hzd_stall_i = 1'b0;
    #1;
    check_eq("hzd_clear", bus.stall_o, 0);
    tick();

    // Mult started in the DONE cycle of a div.
    bus.E_MDstart_i = 1'b1;
    bus.E_MDop_i    = MD_OP_DIVU;
    tick();
    bus.E_MDstart_i = 1'b0;
    repeat (10) tick();
    check_eq("b2b_div_done", bus.MD_done_o, 1);
    bus.E_MDstart_i = 1'b1;
    bus.E_MDop_i    = MD_OP_MULTU;
    #1;
    check_eq("b2b_busy", bus.MD_busy_o, 1);
    check_eq("b2b_done", bus.MD_done_o, 1);
    tick();
    bus.E_MDstart_i = 1'b0;
    #1;
    check_eq("b2b_cnt",   bus.MD_cnt_o,  5);
    check_eq("b2b_bsy2",  bus.MD_busy_o, 1);
    check_eq("b2b_err",   bus.MD_err_o,  0);
    check_eq("b2b_done0", bus.MD_done_o, 0);
    repeat (5) tick();
    check_eq("b2b_mul_done", bus.MD_done_o, 1);
    check_eq("b2b_mul_cnt",  bus.MD_cnt_o,  0);
    tick();

    // Start forced while busy, then reset mid-div.
    bus.E_MDstart_i = 1'b1;
    bus.E_MDop_i    = MD_OP_DIV;
    tick();
    bus.E_MDstart_i = 1'b0;
    tick();
    tick();
    bus.E_MDstart_i = 1'b1;
    bus.E_MDop_i    = MD_OP_MULT;
    #1;
    check_eq("ovl_cnt_t3", bus.MD_cnt_o, 8);
    check_eq("ovl_err0",   bus.MD_err_o, 0);
    tick();
    bus.E_MDstart_i = 1'b0;
    #1;
    check_eq("ovl_err",    bus.MD_err_o, 1);
    check_eq("ovl_cnt_t4", bus.MD_cnt_o, 7);
    tick();
    check_eq("ovl_cnt_t5", bus.MD_cnt_o, 6);
    check_eq("ovl_sticky", bus.MD_err_o, 1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_cnt",  bus.MD_cnt_o,  0);
    check_eq("arst_busy", bus.MD_busy_o, 0);
    check_eq("arst_err",  bus.MD_err_o,  0);
    check_eq("arst_done", bus.MD_done_o, 0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick();
      check_eq("arst_nodone", bus.MD_done_o, 0);
      check_eq("arst_idle",   bus.MD_busy_o, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
